// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the synchronous FIFO read-side logic.
//   SKID_DEPTH : entries in the reader's output register queue
//   OCC_W      : width of the queue occupancy count (0..SKID_DEPTH)
//   occ_t      : occupancy count type
//   beat_width : width needed to hold a burst beat index 0..len-1 (min 1)
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned SKID_DEPTH = 3;
    localparam int unsigned OCC_W      = 2;

    typedef logic [OCC_W-1:0] occ_t;

    function automatic int unsigned beat_width(input int unsigned len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/fifo_skid_queue.sv
// -----------------------------------------------------------------------------
// fifo_skid_queue
// Small in-order register queue that absorbs words returning from the FIFO
// while the stream consumer is stalled. Entry 0 is always the head.
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      reset, synchronous, active-low
//   clear      in   1      drop all entries (contents left stale, occ -> 0)
//   push       in   1      append push_data at the tail
//   push_data  in   WIDTH  word to append
//   pop        in   1      remove the head entry
//   head       out  WIDTH  current head entry
//   occ        out  OCC_W  number of valid entries
// -----------------------------------------------------------------------------
module fifo_skid_queue
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output occ_t             occ
);

    localparam occ_t FULL_OCC = OCC_W'(SKID_DEPTH);
    localparam occ_t ONE_OCC  = OCC_W'(1);

    logic [WIDTH-1:0] mem   [SKID_DEPTH];
    logic [WIDTH-1:0] mem_n [SKID_DEPTH];
    occ_t             occ_n;
    logic             pop_ok;
    logic             push_ok;

    // Pop is applied before push so a simultaneous push into a full queue
    // lands in the slot freed by the pop; occupancy is then unchanged.
    always_comb begin
        pop_ok  = pop && (occ != '0);
        push_ok = push && ((occ != FULL_OCC) || pop_ok);
        mem_n   = mem;
        occ_n   = occ;
        if (pop_ok) begin
            for (int unsigned i = 0; i < SKID_DEPTH - 1; i++) begin
                mem_n[i] = mem[i+1];
            end
            occ_n = occ - ONE_OCC;
        end
        if (push_ok) begin
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                if (OCC_W'(i) == occ_n) begin
                    mem_n[i] = push_data;
                end
            end
            occ_n = occ_n + ONE_OCC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            occ <= '0;
        end else if (clear) begin
            occ <= '0;
        end else begin
            mem <= mem_n;
            occ <= occ_n;
        end
    end

    assign head = mem[0];

endmodule

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
// Read-side controller for the synchronous FIFO. Issues pops on the FIFO read
// port, hides its one-cycle read latency behind a 3-entry register queue and
// presents the words on a valid/ready stream at up to one word per cycle.
// Burst boundaries are flagged with m_last; completed handshakes are counted.
// Ports:
//   clk         in   1      clock, rising edge
//   rst         in   1      reset, synchronous, active-low
//   flush       in   1      discard buffered and in-flight words, clear burst index
//   fifo_empty  in   1      FIFO empty flag
//   fifo_dout   in   WIDTH  FIFO read data, valid the cycle after an accepted rd_en
//   fifo_rd_en  out  1      FIFO pop request
//   m_valid     out  1      stream word valid
//   m_ready     in   1      stream consumer ready
//   m_data      out  WIDTH  stream word
//   m_last      out  1      last beat of the current burst
//   word_cnt    out  CNT_W  completed handshakes since reset (wraps)
// -----------------------------------------------------------------------------
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int unsigned      BEAT_W    = beat_width(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [OCC_W:0]    DEPTH_C   = (OCC_W+1)'(SKID_DEPTH);

    occ_t              occ;
    logic              pending;
    logic [BEAT_W-1:0] beat;
    logic [OCC_W:0]    committed;
    logic              handshake;
    logic              capture;

    // Slots already spoken for: buffered words plus the read still in flight.
    // Only registered state feeds this, so m_ready never reaches fifo_rd_en.
    assign committed  = {1'b0, occ} + {{OCC_W{1'b0}}, pending};
    assign fifo_rd_en = rst & ~flush & ~fifo_empty & (committed < DEPTH_C);

    assign m_valid   = (occ != '0);
    assign handshake = m_valid & m_ready;
    assign m_last    = m_valid & (beat == LAST_BEAT);

    // A word returning during flush belongs to the discarded stream.
    assign capture = pending & ~flush;

    fifo_skid_queue #(
        .WIDTH (WIDTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (capture),
        .push_data (fifo_dout),
        .pop       (handshake),
        .head      (m_data),
        .occ       (occ)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending  <= 1'b0;
            beat     <= '0;
            word_cnt <= '0;
        end else begin
            pending <= fifo_rd_en;
            // A handshake in the flush cycle still completes and is counted.
            if (handshake) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
            if (flush) begin
                beat <= '0;
            end else if (handshake) begin
                beat <= (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);
            end
        end
    end

endmodule
